accum_array: RTL and testbench
==============================

Name: accum_array

Overview:
- Sits directly downstream of the multiplier array in the CONV datapath.
- Consumes the Pout*Pin*Kh*Kw truncated products and, per output channel, reduces them through a registered adder tree.
- Accumulates the tree sums over several Pin-wide input-channel groups and adds a per-channel bias.
- Emits one BIT_WIDTH result per output channel when the pixel completes.

Parameters:
- Kh, 3, kernel height
- Kw, 3, kernel width
- Pin, 2, input feature map parallelism
- Pout, 1, output feature map parallelism
- BIT_WIDTH, 8, data path width (products, bias, outputs; signed two's complement)
- ACC_WIDTH, 24, accumulator width; must be >= BIT_WIDTH + clog2(Pin*Kh*Kw) + GRP_WIDTH
- GRP_WIDTH, 8, width of the input-group count

Ports:
- clk  input  1  system clock
- rst  input  1  system reset; synchronous, active-high
- accum_en  input  1  product vector valid (from multiplier array valid)
- mult_array_data  input  Pout*Pin*Kh*Kw*BIT_WIDTH  products; product (i,j,k,l) at [(i*Pin*Kh*Kw+j*Kh*Kw+k*Kw+l)*BIT_WIDTH +: BIT_WIDTH]
- bias_in  input  Pout*BIT_WIDTH  per-channel bias; channel i at [i*BIT_WIDTH +: BIT_WIDTH]
- num_in_group  input  GRP_WIDTH  input-channel groups per output pixel (Cin/Pin)
- accum_clr  input  1  synchronous abort of the partial sum in flight
- accum_valid  output  1  one-cycle pulse: accum_data holds a finished pixel
- accum_data  output  Pout*BIT_WIDTH  results; channel i at [i*BIT_WIDTH +: BIT_WIDTH]

Behaviour:
- Reset (rst=1 at posedge): tree_valid, accum_valid, group counter, accumulators and accum_data all clear to 0; the FSM goes to IDLE.
- Stage 1, adder tree:
  - On accum_en, each channel i sums its Pin*Kh*Kw sign-extended products at full precision.
  - The sum is registered into tree_sum[i]; tree_valid <= accum_en one cycle later.
- Stage 2, accumulator and FSM. The group counter grp_cnt runs 0..N-1. N = num_in_group sampled at the posedge where tree_valid=1 and state=IDLE; N=0 is treated as 1.
- IDLE, tree_valid=1:
  - acc[i] <= sext(bias_in[i]) + tree_sum[i].
  - If N==1: output fires and the FSM stays in IDLE.
  - Otherwise: grp_cnt <= 1 and the FSM goes to ACCUM.
- ACCUM, tree_valid=1:
  - acc[i] <= acc[i] + tree_sum[i]; grp_cnt++.
  - When grp_cnt == N-1: output fires, grp_cnt <= 0, FSM -> IDLE.
- tree_valid=0: no state change. Gaps between groups of any length are allowed.
- Bias is sampled only on the first group of each pixel.
- Output fire, registered at the same edge as the final accumulate:
  - accum_valid <= 1 for exactly one cycle.
  - accum_data[i] <= conv(acc_next[i]).
  - accum_data holds its value until the next fire.
- conv(): default takes the low BIT_WIDTH bits (wrap); see Optional Feature.
- Latency: accum_en of the last group at edge t produces accum_valid=1 after edge t+2.
- Throughput: one product vector per cycle, back-to-back. No backpressure; accum_en is never stalled.
- Pixel boundary: the first group of the next pixel may arrive on the cycle after the last group; its bias path is used with no bubble.
- accum_clr=1 at a posedge:
  - Clears tree_valid, grp_cnt and acc; FSM -> IDLE; accum_valid <= 0.
  - A simultaneous accum_en is discarded (clr wins).
  - accum_data keeps its old value.
- num_in_group changing mid-pixel has no effect until the next IDLE sample.
- Reset mid-operation: the partial sum is lost and no accum_valid is generated for it.

Optional Feature:
- Macro: ACCUM_SATURATE_EN.
- Defined: conv() saturates the signed ACC_WIDTH value to the BIT_WIDTH range: > 2^(BIT_WIDTH-1)-1 gives 0x7F..F; < -2^(BIT_WIDTH-1) gives 0x80..0.
- Undefined: conv() truncates to the low BIT_WIDTH bits with no overflow handling, which removes the comparators.

Test Plan (Kh=Kw=3, Pin=2, Pout=1, BIT_WIDTH=8, ACC_WIDTH=24):
- All 18 products=0x01, bias=0, num_in_group=1, single accum_en pulse -> accum_valid pulses once, 2 cycles later, with accum_data=0x12.
- Products=0x02, bias=0x05, num_in_group=3, three back-to-back accum_en -> exactly one accum_valid, 2 cycles after the 3rd, with data=0x71 (5+3*36=113); repeat with 2-cycle gaps between groups -> same result.
- Products=0xFF (-1), bias=0, num_in_group=1 -> data=0xEE (-18).
- Products=0x7F, bias=0, num_in_group=1 -> sum 2286; without ACCUM_SATURATE_EN data=0xEE; with it data=0x7F. All products 0x80 with saturation -> 0x80.
- num_in_group=3, two groups of 0x01, accum_clr asserted together with a 3rd accum_en, then three new groups of 0x02 with bias 0 -> single result 0x6C (108) and no accum_valid for the aborted pixel; repeat with rst instead of accum_clr -> all outputs 0, same subsequent result.
- Two pixels back-to-back (num_in_group=2, bias 1 then bias 2, products 0x01) -> accum_valid on two cycles exactly 2 apart, data 0x25 then 0x26.

Source files
------------

// File: rtl/accum_array.sv
// accum_array: per-output-channel reduction of multiplier-array products.
// Stage 1 sums Pin*Kh*Kw sign-extended products per channel into a register.
// Stage 2 accumulates those sums over num_in_group input-channel groups,
// adds the channel bias on the first group, and emits one result per pixel.
// Optional feature macro: ACCUM_SATURATE_EN (saturate instead of wrap on output).
module accum_array #(
  parameter int Kh        = 3,
  parameter int Kw        = 3,
  parameter int Pin       = 2,
  parameter int Pout      = 1,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 24,
  parameter int GRP_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        accum_en,
  input  logic [Pout*Pin*Kh*Kw*BIT_WIDTH-1:0] mult_array_data,
  input  logic [Pout*BIT_WIDTH-1:0]   bias_in,
  input  logic [GRP_WIDTH-1:0]        num_in_group,
  input  logic                        accum_clr,
  output logic                        accum_valid,
  output logic [Pout*BIT_WIDTH-1:0]   accum_data
);

  localparam int NPROD = Pin * Kh * Kw;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                       state, state_next;
  logic                         tree_valid;
  logic signed [ACC_WIDTH-1:0]  tree_comb [Pout];
  logic signed [ACC_WIDTH-1:0]  tree_sum  [Pout];
  logic signed [ACC_WIDTH-1:0]  acc       [Pout];
  logic signed [ACC_WIDTH-1:0]  acc_next  [Pout];
  logic [BIT_WIDTH-1:0]         conv_out  [Pout];
  logic [GRP_WIDTH-1:0]         grp_cnt, grp_cnt_next;
  logic [GRP_WIDTH-1:0]         grp_n, grp_n_next;
  logic [GRP_WIDTH-1:0]         n_eff;
  logic                         fire;

  // Full-precision sum of each channel's sign-extended products.
  always_comb begin
    for (int i = 0; i < Pout; i++) begin
      tree_comb[i] = '0;
      for (int p = 0; p < NPROD; p++) begin
        tree_comb[i] = tree_comb[i]
          + ACC_WIDTH'($signed(mult_array_data[(i*NPROD+p)*BIT_WIDTH +: BIT_WIDTH]));
      end
    end
  end

  // Stage 1 register: capture tree sums; a clear discards a simultaneous product vector.
  always_ff @(posedge clk) begin
    if (rst || accum_clr) begin
      tree_valid <= 1'b0;
    end else begin
      tree_valid <= accum_en;
    end
    // NOTE: tree_sum is pure datapath qualified by tree_valid, so it carries no reset.
    if (accum_en) begin
      for (int i = 0; i < Pout; i++) tree_sum[i] <= tree_comb[i];
    end
  end

  assign n_eff = (num_in_group == '0) ? GRP_WIDTH'(1) : num_in_group;

  // Next-state logic: group counting, accumulation and the output-fire decision.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_next   = state;
    grp_cnt_next = grp_cnt;
    grp_n_next   = grp_n;
    fire         = 1'b0;
    for (int i = 0; i < Pout; i++) acc_next[i] = acc[i];

    if (tree_valid) begin
      unique case (state)
        IDLE: begin
          for (int i = 0; i < Pout; i++) begin
            acc_next[i] = ACC_WIDTH'($signed(bias_in[i*BIT_WIDTH +: BIT_WIDTH])) + tree_sum[i];
          end
          grp_n_next = n_eff;
          if (n_eff == GRP_WIDTH'(1)) begin
            fire = 1'b1;
          end else begin
            grp_cnt_next = GRP_WIDTH'(1);
            state_next   = ACCUM;
          end
        end
        ACCUM: begin
          for (int i = 0; i < Pout; i++) acc_next[i] = acc[i] + tree_sum[i];
          if (grp_cnt == grp_n - GRP_WIDTH'(1)) begin
            fire         = 1'b1;
            grp_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            grp_cnt_next = grp_cnt + GRP_WIDTH'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Conversion of the wide accumulator to the output width.
  always_comb begin
    for (int i = 0; i < Pout; i++) begin
`ifdef ACCUM_SATURATE_EN
      if (acc_next[i] > ACC_WIDTH'((1 << (BIT_WIDTH-1)) - 1)) begin
        conv_out[i] = {1'b0, {(BIT_WIDTH-1){1'b1}}};
      end else if (acc_next[i] < -ACC_WIDTH'(1 << (BIT_WIDTH-1))) begin
        conv_out[i] = {1'b1, {(BIT_WIDTH-1){1'b0}}};
      end else begin
        conv_out[i] = acc_next[i][BIT_WIDTH-1:0];
      end
`else
      conv_out[i] = acc_next[i][BIT_WIDTH-1:0];
`endif
    end
  end

  // Stage 2 registers: FSM state, counters, accumulators and the output port.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state       <= IDLE;
      grp_cnt     <= '0;
      grp_n       <= '0;
      accum_valid <= 1'b0;
      accum_data  <= '0;
      for (int i = 0; i < Pout; i++) acc[i] <= '0;
    end else if (accum_clr) begin
      state       <= IDLE;
      grp_cnt     <= '0;
      accum_valid <= 1'b0;
      for (int i = 0; i < Pout; i++) acc[i] <= '0;
    end else begin
      state       <= state_next;
      grp_cnt     <= grp_cnt_next;
      grp_n       <= grp_n_next;
      accum_valid <= fire;
      for (int i = 0; i < Pout; i++) acc[i] <= acc_next[i];
      if (fire) begin
        for (int i = 0; i < Pout; i++) accum_data[i*BIT_WIDTH +: BIT_WIDTH] <= conv_out[i];
      end
    end
  end

endmodule

// File: tb/tb_accum_array.sv
// Self-checking bench for accum_array (Kh=Kw=3, Pin=2, Pout=1, BIT_WIDTH=8).
// Expected results are pushed to a scoreboard when the last group of a pixel
// is driven; a negedge monitor pops and compares data and arrival cycle.
module tb_accum_array;

  localparam int NPROD = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic         accum_en;
  logic [NPROD*8-1:0] mult_array_data;
  logic [7:0]   bias_in;
  logic [7:0]   num_in_group;
  logic         accum_clr;
  logic         accum_valid;
  logic [7:0]   accum_data;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q [$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_exp = 8'h00;

  accum_array #(
    .Kh(3), .Kw(3), .Pin(2), .Pout(1),
    .BIT_WIDTH(8), .ACC_WIDTH(24), .GRP_WIDTH(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .accum_en       (accum_en),
    .mult_array_data(mult_array_data),
    .bias_in        (bias_in),
    .num_in_group   (num_in_group),
    .accum_clr      (accum_clr),
    .accum_valid    (accum_valid),
    .accum_data     (accum_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: bias + groups * 18 * product, then wrap or saturate.
  function automatic logic [7:0] model(input logic [7:0] bias, input logic [7:0] prod,
                                       input int groups);
    int s;
    s = int'($signed(bias)) + groups * NPROD * int'($signed(prod));
`ifdef ACCUM_SATURATE_EN
    if (s > 127) return 8'h7F;
    if (s < -128) return 8'h80;
`endif
    return s[7:0];
  endfunction

  // Monitor: every accum_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (accum_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: accum_valid=1 data=%02h at cycle %0d, none expected",
                 accum_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (accum_data !== e.data) begin
          n_fail++;
          $display("FAIL result_data: got %02h expected %02h (cycle %0d)", accum_data, e.data, cyc);
        end
        n_checks++;
        if (cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL result_latency: valid at cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  // Drive one cycle of inputs, just after a rising edge.
  task automatic put(input logic en, input logic [7:0] prod, input logic [7:0] bias);
    @(posedge clk);
    #1;
    accum_en        = en;
    mult_array_data = {NPROD{prod}};
    bias_in         = bias;
  endtask

  task automatic expect_result(input logic [7:0] data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
    last_exp = data;
  endtask

  // Wait a bounded number of cycles, then require the scoreboard to be empty.
  task automatic drain(input string name);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; accum_en = 1'b0; accum_clr = 1'b0;
    mult_array_data = '0; bias_in = 8'h00; num_in_group = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (accum_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", accum_valid);
    end
    n_checks++;
    if (accum_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %02h expected 00", accum_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    num_in_group = 8'd1;
    put(1'b1, 8'h01, 8'h00); expect_result(8'h12);
    put(1'b0, 8'h01, 8'h00);
    drain("single");
    // A group count of zero behaves as one group.
    num_in_group = 8'd0;
    put(1'b1, 8'h01, 8'h03); expect_result(model(8'h03, 8'h01, 1));
    put(1'b0, 8'h01, 8'h03);
    drain("zero_groups");
  endtask

  task automatic test_multi_group();
    num_in_group = 8'd3;
    put(1'b1, 8'h02, 8'h05);
    put(1'b1, 8'h02, 8'h05);
    put(1'b1, 8'h02, 8'h05); expect_result(8'h71);
    put(1'b0, 8'h02, 8'h05);
    drain("multi_group");
  endtask

  task automatic test_gaps();
    num_in_group = 8'd3;
    for (int g = 0; g < 3; g++) begin
      put(1'b1, 8'h02, 8'h05);
      if (g == 2) expect_result(8'h71);
      // Changing the group count mid-pixel must not disturb this pixel.
      if (g == 1) num_in_group = 8'd1;
      put(1'b0, 8'h02, 8'h05);
      put(1'b0, 8'h02, 8'h05);
    end
    drain("gaps");
    num_in_group = 8'd3;
  endtask

  task automatic test_signed();
    logic [7:0] prods [3];
    prods[0] = 8'hFF; prods[1] = 8'h7F; prods[2] = 8'h80;
    num_in_group = 8'd1;
    for (int k = 0; k < 3; k++) begin
      put(1'b1, prods[k], 8'h00); expect_result(model(8'h00, prods[k], 1));
      put(1'b0, prods[k], 8'h00);
      drain("signed");
    end
  endtask

  task automatic test_abort(input bit use_rst);
    num_in_group = 8'd3;
    put(1'b1, 8'h01, 8'h00);
    put(1'b1, 8'h01, 8'h00);
    put(1'b1, 8'h01, 8'h00);
    if (use_rst) rst = 1'b1; else accum_clr = 1'b1;
    put(1'b0, 8'h01, 8'h00);
    rst = 1'b0; accum_clr = 1'b0;
    n_checks++;
    if (accum_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_valid: got %b expected 0", accum_valid);
    end
    n_checks++;
    if (accum_data !== (use_rst ? 8'h00 : last_exp)) begin
      n_fail++;
      $display("FAIL abort_data: got %02h expected %02h", accum_data,
               use_rst ? 8'h00 : last_exp);
    end
    put(1'b1, 8'h02, 8'h00);
    put(1'b1, 8'h02, 8'h00);
    put(1'b1, 8'h02, 8'h00); expect_result(8'h6C);
    put(1'b0, 8'h02, 8'h00);
    drain(use_rst ? "rst_abort" : "clr_abort");
  endtask

  task automatic test_back_to_back();
    num_in_group = 8'd2;
    put(1'b1, 8'h01, 8'h01);
    put(1'b1, 8'h01, 8'h01); expect_result(8'h25);
    put(1'b1, 8'h01, 8'h02);
    put(1'b1, 8'h01, 8'h02); expect_result(8'h26);
    put(1'b0, 8'h01, 8'h02);
    drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_group();
    test_gaps();
    test_signed();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
